// File: rtl/mem_access_ctrl_if.sv
// Purpose : request/acknowledge data-bus bundle between the MEM-stage
//           controller (master) and the data memory (slave).
// Signals : bus_en    request, held high for the whole transfer
//           bus_we    1 = write, 0 = read
//           bus_sel   byte-lane enables
//           bus_addr  word-aligned address
//           bus_wdata lane-replicated store data
//           bus_rdata read data, valid with bus_ack
//           bus_ack   transfer complete
interface mem_access_ctrl_if;
    logic        bus_en;
    logic        bus_we;
    logic [3:0]  bus_sel;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    modport master (
        output bus_en, bus_we, bus_sel, bus_addr, bus_wdata,
        input  bus_rdata, bus_ack
    );

    modport slave (
        input  bus_en, bus_we, bus_sel, bus_addr, bus_wdata,
        output bus_rdata, bus_ack
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Purpose : MEM-stage controller. Turns the ID/EX memory control bundle into
//           a single request/acknowledge bus transfer, stalls the pipeline
//           until the transfer ends, and returns aligned/extended load data.
//           Flags misaligned accesses and abandons transfers that time out.
// Ports   : clk, rst             clock, synchronous active-high reset
//           i_mem_read_flag      load request
//           i_mem_write_flag     store request (wins if both flags set)
//           i_mem_sign_ext_flag  sign-extend load result
//           i_mem_sel            0001 byte, 0011 half, 1111 word
//           i_mem_addr           byte address
//           i_mem_write_data     right-justified store data
//           i_flush              flush of the current MEM instruction
//           o_stall_req          pipeline freeze (combinational)
//           o_load_data          extended load result (registered)
//           o_addr_err_load      misaligned load (combinational)
//           o_addr_err_store     misaligned store (combinational)
//           o_bus_err            timeout pulse in the DONE cycle (registered)
//           bus                  data-bus master port
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_mem_read_flag,
    input  logic                      i_mem_write_flag,
    input  logic                      i_mem_sign_ext_flag,
    input  logic [3:0]                i_mem_sel,
    input  logic [31:0]               i_mem_addr,
    input  logic [31:0]               i_mem_write_data,
    input  logic                      i_flush,
    output logic                      o_stall_req,
    output logic [31:0]               o_load_data,
    output logic                      o_addr_err_load,
    output logic                      o_addr_err_store,
    output logic                      o_bus_err,
    mem_access_ctrl_if.master         bus
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state,     w_state_nxt;
    logic        r_bus_en,    w_bus_en_nxt;
    logic        r_bus_we,    w_bus_we_nxt;
    logic [3:0]  r_bus_sel,   w_bus_sel_nxt;
    logic [31:0] r_bus_addr,  w_bus_addr_nxt;
    logic [31:0] r_bus_wdata, w_bus_wdata_nxt;
    logic [31:0] r_load_data, w_load_data_nxt;
    logic        r_bus_err,   w_bus_err_nxt;
    logic [CNT_W-1:0] r_cnt,  w_cnt_nxt;
    logic        r_discard,   w_discard_nxt;
    logic [1:0]  r_offset,    w_offset_nxt;
    logic [3:0]  r_size,      w_size_nxt;
    logic        r_sign,      w_sign_nxt;

    logic        w_req;
    logic        w_misaligned;
    logic        w_idle;
    logic        w_accept;
    logic        w_discard_now;
    logic [31:0] w_wdata_rep;
    logic [31:0] w_rshift;
    logic [31:0] w_load_ext;

    // Request qualification and alignment check
    assign w_req  = i_mem_read_flag | i_mem_write_flag;
    assign w_idle = (r_state == S_IDLE);

    always_comb begin
        w_misaligned = 1'b1;
        case (i_mem_sel)
            4'b0001: w_misaligned = 1'b0;
            4'b0011: w_misaligned = i_mem_addr[0];
            4'b1111: w_misaligned = |i_mem_addr[1:0];
            default: w_misaligned = 1'b1;
        endcase
    end

    assign w_accept         = w_idle & w_req & ~w_misaligned & ~i_flush;
    assign o_addr_err_store = w_idle & i_mem_write_flag & w_misaligned;
    assign o_addr_err_load  = w_idle & i_mem_read_flag & ~i_mem_write_flag & w_misaligned;
    assign o_stall_req      = w_accept | (r_state == S_BUSY);

    // Store data replicated across every lane the access could land in
    always_comb begin
        w_wdata_rep = i_mem_write_data;
        case (i_mem_sel)
            4'b0001: w_wdata_rep = {4{i_mem_write_data[7:0]}};
            4'b0011: w_wdata_rep = {2{i_mem_write_data[15:0]}};
            default: w_wdata_rep = i_mem_write_data;
        endcase
    end

    // Load lane extraction and extension from the latched size/offset
    assign w_rshift = bus.bus_rdata >> {r_offset, 3'b000};

    always_comb begin
        w_load_ext = w_rshift;
        case (r_size)
            4'b0001: w_load_ext = {{24{r_sign & w_rshift[7]}},  w_rshift[7:0]};
            4'b0011: w_load_ext = {{16{r_sign & w_rshift[15]}}, w_rshift[15:0]};
            default: w_load_ext = w_rshift;
        endcase
    end

    // A flush arriving in the completing cycle still discards the result
    assign w_discard_now = r_discard | i_flush;

    // Next-state and next-register values
    always_comb begin
        w_state_nxt     = r_state;
        w_bus_en_nxt    = r_bus_en;
        w_bus_we_nxt    = r_bus_we;
        w_bus_sel_nxt   = r_bus_sel;
        w_bus_addr_nxt  = r_bus_addr;
        w_bus_wdata_nxt = r_bus_wdata;
        w_load_data_nxt = r_load_data;
        w_bus_err_nxt   = 1'b0;
        w_cnt_nxt       = r_cnt;
        w_discard_nxt   = r_discard;
        w_offset_nxt    = r_offset;
        w_size_nxt      = r_size;
        w_sign_nxt      = r_sign;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt     = S_BUSY;
                    w_bus_en_nxt    = 1'b1;
                    w_bus_we_nxt    = i_mem_write_flag;
                    w_bus_sel_nxt   = 4'(i_mem_sel << i_mem_addr[1:0]);
                    w_bus_addr_nxt  = {i_mem_addr[31:2], 2'b00};
                    w_bus_wdata_nxt = w_wdata_rep;
                    w_cnt_nxt       = '0;
                    w_discard_nxt   = 1'b0;
                    w_offset_nxt    = i_mem_addr[1:0];
                    w_size_nxt      = i_mem_sel;
                    w_sign_nxt      = i_mem_sign_ext_flag;
                end
            end
            S_BUSY: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (i_flush) begin
                    w_discard_nxt = 1'b1;
                end
                if (bus.bus_ack) begin
                    w_bus_en_nxt = 1'b0;
                    if (!r_bus_we && !w_discard_now) begin
                        w_load_data_nxt = w_load_ext;
                    end
                    w_state_nxt = w_discard_now ? S_IDLE : S_DONE;
                end else if (r_cnt == CNT_LAST) begin
                    w_bus_en_nxt = 1'b0;
                    if (!w_discard_now) begin
                        w_bus_err_nxt = 1'b1;
                        if (!r_bus_we) begin
                            w_load_data_nxt = '0;
                        end
                    end
                    w_state_nxt = w_discard_now ? S_IDLE : S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_bus_en    <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_sel   <= '0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_load_data <= '0;
            r_bus_err   <= 1'b0;
            r_cnt       <= '0;
            r_discard   <= 1'b0;
            r_offset    <= '0;
            r_size      <= '0;
            r_sign      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_bus_en    <= w_bus_en_nxt;
            r_bus_we    <= w_bus_we_nxt;
            r_bus_sel   <= w_bus_sel_nxt;
            r_bus_addr  <= w_bus_addr_nxt;
            r_bus_wdata <= w_bus_wdata_nxt;
            r_load_data <= w_load_data_nxt;
            r_bus_err   <= w_bus_err_nxt;
            r_cnt       <= w_cnt_nxt;
            r_discard   <= w_discard_nxt;
            r_offset    <= w_offset_nxt;
            r_size      <= w_size_nxt;
            r_sign      <= w_sign_nxt;
        end
    end

    assign bus.bus_en    = r_bus_en;
    assign bus.bus_we    = r_bus_we;
    assign bus.bus_sel   = r_bus_sel;
    assign bus.bus_addr  = r_bus_addr;
    assign bus.bus_wdata = r_bus_wdata;
    assign o_load_data   = r_load_data;
    assign o_bus_err     = r_bus_err;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl (TIMEOUT_CYCLES = 4).
module tb_mem_access_ctrl;

    logic        clk;
    logic        rst;
    logic        rd, wr, sgn, flush;
    logic [3:0]  sel;
    logic [31:0] addr, wdata;
    logic        stall_req, err_ld, err_st, bus_err;
    logic [31:0] load_data;

    int checks = 0;
    int errors = 0;
    logic [31:0] model_load;

    mem_access_ctrl_if bus_if ();

    mem_access_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .i_mem_read_flag     (rd),
        .i_mem_write_flag    (wr),
        .i_mem_sign_ext_flag (sgn),
        .i_mem_sel           (sel),
        .i_mem_addr          (addr),
        .i_mem_write_data    (wdata),
        .i_flush             (flush),
        .o_stall_req         (stall_req),
        .o_load_data         (load_data),
        .o_addr_err_load     (err_ld),
        .o_addr_err_store    (err_st),
        .o_bus_err           (bus_err),
        .bus                 (bus_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd, wr, sgn;
        logic [3:0]  sel;
        logic [31:0] addr, wdata, rdata;
        int          ack_wait;
        logic        e_err_ld, e_err_st, e_we;
        logic [3:0]  e_sel;
        logic [31:0] e_addr, e_wdata, e_load;
        int          e_stalls, e_en;
        logic        e_berr;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drop_req();
        rd = 1'b0; wr = 1'b0; sgn = 1'b0; sel = 4'b0000;
        addr = '0; wdata = '0; flush = 1'b0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int  stalls;
        int  en_cnt;
        int  k;
        bit  done;
        @(negedge clk);
        rd = v.rd; wr = v.wr; sgn = v.sgn; sel = v.sel;
        addr = v.addr; wdata = v.wdata; flush = 1'b0;
        bus_if.bus_ack = 1'b0; bus_if.bus_rdata = v.rdata;
        #1;
        chk($sformatf("v%0d err_load", idx), 32'(err_ld), 32'(v.e_err_ld));
        chk($sformatf("v%0d err_store", idx), 32'(err_st), 32'(v.e_err_st));
        if (v.e_err_ld || v.e_err_st) begin
            chk($sformatf("v%0d err stall", idx), 32'(stall_req), 32'd0);
            repeat (2) begin
                @(negedge clk); #1;
                chk($sformatf("v%0d err no bus_en", idx), 32'(bus_if.bus_en), 32'd0);
            end
            drop_req();
            return;
        end
        stalls = stall_req ? 1 : 0;
        en_cnt = 0;
        k = 0;
        done = 1'b0;
        for (int c = 0; c < 30 && !done; c++) begin
            @(negedge clk); #1;
            if (bus_if.bus_en) en_cnt++;
            if (k == 0) begin
                chk($sformatf("v%0d bus_sel", idx), 32'(bus_if.bus_sel), 32'(v.e_sel));
                chk($sformatf("v%0d bus_addr", idx), bus_if.bus_addr, v.e_addr);
                chk($sformatf("v%0d bus_wdata", idx), bus_if.bus_wdata, v.e_wdata);
                chk($sformatf("v%0d bus_we", idx), 32'(bus_if.bus_we), 32'(v.e_we));
            end
            if (stall_req) begin
                stalls++;
                bus_if.bus_ack = (k == v.ack_wait);
                k++;
            end else begin
                done = 1'b1;
                bus_if.bus_ack = 1'b0;
                chk($sformatf("v%0d load_data", idx), load_data, v.e_load);
                chk($sformatf("v%0d bus_err", idx), 32'(bus_err), 32'(v.e_berr));
                chk($sformatf("v%0d stall cycles", idx), 32'(stalls), 32'(v.e_stalls));
                chk($sformatf("v%0d bus_en cycles", idx), 32'(en_cnt), 32'(v.e_en));
                drop_req();
            end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL v%0d completion actual=stalled required=done", idx);
            drop_req();
        end
        model_load = v.e_load;
        @(negedge clk); #1;
        chk($sformatf("v%0d bus_err after", idx), 32'(bus_err), 32'd0);
        chk($sformatf("v%0d idle stall", idx), 32'(stall_req), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        drop_req();
        bus_if.bus_ack = 1'b0;
        bus_if.bus_rdata = '0;
        model_load = '0;

        //           rd    wr    sgn   sel      addr          wdata         rdata         wait eld   est   we    esel     eaddr         ewdata        eload         st en berr
        vecs[0]  = '{1'b1, 1'b0, 1'b1, 4'b0001, 32'h0000_1003, 32'h0,        32'h8011_2233, 0,  1'b0, 1'b0, 1'b0, 4'b1000, 32'h0000_1000, 32'h0,        32'hFFFF_FF80, 2, 1, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 4'b0011, 32'h0000_2002, 32'h0,        32'hBEEF_1234, 3,  1'b0, 1'b0, 1'b0, 4'b1100, 32'h0000_2000, 32'h0,        32'h0000_BEEF, 5, 4, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 4'b0001, 32'h0000_0001, 32'h0000_00A5, 32'h0,        1,  1'b0, 1'b0, 1'b1, 4'b0010, 32'h0000_0000, 32'hA5A5_A5A5, 32'h0000_BEEF, 3, 2, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 4'b1111, 32'h0000_0006, 32'h0,        32'h0,        0,  1'b1, 1'b0, 1'b0, 4'b0000, 32'h0,        32'h0,        32'h0,        0, 0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 4'b0011, 32'h0000_0003, 32'h0,        32'h0,        0,  1'b0, 1'b1, 1'b1, 4'b0000, 32'h0,        32'h0,        32'h0,        0, 0, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 4'b1111, 32'h0000_3000, 32'h0,        32'h5555_5555, 255, 1'b0, 1'b0, 1'b0, 4'b1111, 32'h0000_3000, 32'h0,        32'h0000_0000, 5, 4, 1'b1};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 4'b1111, 32'h0000_4000, 32'h0,        32'hCAFE_F00D, 0,  1'b0, 1'b0, 1'b0, 4'b1111, 32'h0000_4000, 32'h0,        32'hCAFE_F00D, 2, 1, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 4'b0011, 32'h0000_0002, 32'h0,        32'h8001_7FFF, 1,  1'b0, 1'b0, 1'b0, 4'b1100, 32'h0000_0000, 32'h0,        32'hFFFF_8001, 3, 2, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 4'b0001, 32'h0000_0002, 32'h0,        32'h00F0_0000, 2,  1'b0, 1'b0, 1'b0, 4'b0100, 32'h0000_0000, 32'h0,        32'h0000_00F0, 4, 3, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 4'b1111, 32'h0000_0010, 32'h1122_3344, 32'hFFFF_FFFF, 0,  1'b0, 1'b0, 1'b1, 4'b1111, 32'h0000_0010, 32'h1122_3344, 32'h0000_00F0, 2, 1, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 4'b0011, 32'h0000_0022, 32'h0000_BEEF, 32'hFFFF_FFFF, 0,  1'b0, 1'b0, 1'b1, 4'b1100, 32'h0000_0020, 32'hBEEF_BEEF, 32'h0000_00F0, 2, 1, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 4'b0101, 32'h0000_0000, 32'h0,        32'h0,        0,  1'b1, 1'b0, 1'b0, 4'b0000, 32'h0,        32'h0,        32'h0,        0, 0, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 4'b1111, 32'h0000_0001, 32'h0,        32'h0,        0,  1'b0, 1'b1, 1'b1, 4'b0000, 32'h0,        32'h0,        32'h0,        0, 0, 1'b0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset bus_en", 32'(bus_if.bus_en), 32'd0);
        chk("reset bus_sel", 32'(bus_if.bus_sel), 32'd0);
        chk("reset bus_addr", bus_if.bus_addr, 32'd0);
        chk("reset load_data", load_data, 32'd0);
        chk("reset bus_err", 32'(bus_err), 32'd0);
        chk("reset stall", 32'(stall_req), 32'd0);

        for (int i = 0; i < 13; i++) run_vec(i, vecs[i]);

        // Flush while idle suppresses the request
        @(negedge clk);
        rd = 1'b1; sel = 4'b1111; addr = 32'h0000_6000; flush = 1'b1;
        #1;
        chk("idle flush stall", 32'(stall_req), 32'd0);
        @(negedge clk); #1;
        chk("idle flush bus_en", 32'(bus_if.bus_en), 32'd0);
        drop_req();

        // Flush during BUSY: transfer completes, result discarded, DONE skipped
        @(negedge clk);
        rd = 1'b1; sel = 4'b1111; addr = 32'h0000_5000;
        bus_if.bus_rdata = 32'h1234_5678;
        #1;
        chk("busy flush accept stall", 32'(stall_req), 32'd1);
        @(negedge clk); #1;
        chk("busy flush bus_en", 32'(bus_if.bus_en), 32'd1);
        flush = 1'b1;
        @(negedge clk); #1;
        chk("busy flush stall held", 32'(stall_req), 32'd1);
        flush = 1'b0;
        drop_req();
        bus_if.bus_ack = 1'b1;
        @(negedge clk); #1;
        bus_if.bus_ack = 1'b0;
        chk("discard stall", 32'(stall_req), 32'd0);
        chk("discard bus_en", 32'(bus_if.bus_en), 32'd0);
        chk("discard load_data", load_data, model_load);
        chk("discard bus_err", 32'(bus_err), 32'd0);
        @(negedge clk); #1;
        chk("discard load later", load_data, model_load);

        // Reset in the middle of a transfer
        @(negedge clk);
        rd = 1'b1; sel = 4'b1111; addr = 32'h0000_7000;
        @(negedge clk); #1;
        chk("rst busy bus_en", 32'(bus_if.bus_en), 32'd1);
        rst = 1'b1;
        drop_req();
        @(negedge clk); #1;
        chk("rst bus_en", 32'(bus_if.bus_en), 32'd0);
        chk("rst stall", 32'(stall_req), 32'd0);
        chk("rst bus_err", 32'(bus_err), 32'd0);
        rst = 1'b0;

        // Stray ack while idle is ignored
        bus_if.bus_rdata = 32'hDEAD_BEEF;
        bus_if.bus_ack = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        bus_if.bus_ack = 1'b0;
        chk("stray ack bus_en", 32'(bus_if.bus_en), 32'd0);
        chk("stray ack load_data", load_data, 32'd0);
        chk("stray ack bus_err", 32'(bus_err), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- MEM-stage controller that sequences data-memory accesses onto a request/acknowledge data bus.
- Consumes the ID-generated memory control bundle (read/write flags, sign-extend flag, byte-lane size select, write data) plus the EX-computed address.
- Aligns lanes and data, holds the pipeline via stall_req until the bus completes, and returns extended load data.
- Detects misaligned accesses and bus timeouts.

Parameters:
- TIMEOUT_CYCLES, 255: BUSY cycles without bus_ack before the access is abandoned (range 1..255, 8-bit counter).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- mem_read_flag  input  1  load request
- mem_write_flag  input  1  store request
- mem_sign_ext_flag  input  1  sign-extend load result
- mem_sel  input  4  size: 0001 byte, 0011 half, 1111 word; others illegal
- mem_addr  input  32  byte address
- mem_write_data  input  32  store data, right-justified
- flush  input  1  pipeline flush for the current MEM instruction
- stall_req  output  1  freeze pipeline (combinational)
- load_data  output  32  extended load result, registered
- addr_err_load  output  1  misaligned load (combinational)
- addr_err_store  output  1  misaligned store (combinational)
- bus_err  output  1  timeout pulse, registered
- bus_en  output  1  bus request, registered
- bus_we  output  1  bus write, registered
- bus_sel  output  4  byte enables, registered
- bus_addr  output  32  word address {mem_addr[31:2],2'b00}, registered
- bus_wdata  output  32  lane-replicated store data, registered
- bus_rdata  input  32  read data, valid with bus_ack
- bus_ack  input  1  transfer complete

Behaviour:
- Reset: state IDLE; all registered outputs, timeout counter, discard flag and offset register = 0.
- rst mid-transaction: bus_en = 0 on the following edge; no DONE cycle and no bus_err.
- req = mem_read_flag | mem_write_flag. If both flags are set, treat the access as a write.
- Misalignment:
  - half: addr[0] = 1
  - word: addr[1:0] != 0
  - illegal mem_sel: always misaligned
- Misaligned request in IDLE:
  - addr_err_load / addr_err_store = 1, matching the access type.
  - No bus cycle, stall_req = 0, state stays IDLE.
- Error outputs are 0 outside IDLE.
- accept = IDLE & req & aligned & ~flush.
- States:
  - IDLE: on accept, register bus_en = 1, bus_we, bus_addr, bus_sel = mem_sel << mem_addr[1:0], bus_wdata, offset = mem_addr[1:0], size, and sign flag; go to BUSY.
  - BUSY: hold all bus_* outputs stable and increment the counter each cycle.
    - On bus_ack: register bus_en = 0; latch extracted read data into load_data if this is a load and not discarded; go to DONE, or to IDLE if discarded.
    - If the counter reaches TIMEOUT_CYCLES without ack: bus_en = 0; load_data = 0 for loads; bus_err = 1; go to DONE (IDLE if discarded, with no bus_err).
  - DONE: one cycle, stall_req = 0 so the pipeline advances; bus_err drops to 0 on exit; next state is IDLE. No new request is accepted in DONE.
- bus_wdata: byte replicated x4, half replicated x2, word unchanged.
- Load extraction:
  - x = bus_rdata >> (8*offset).
  - byte: x[7:0] extended, using x[7] as the sign bit if the sign flag is set, else zero-extend.
  - half: x[15:0] extended, using x[15] as the sign bit if the sign flag is set.
  - word: x unchanged.
- stall_req = (IDLE & accept) | BUSY.
- Minimum latency with ack in the first BUSY cycle:
  - request at T; bus_en high T+1; DONE at T+2.
  - Two stall cycles; load_data valid in the DONE cycle.
- Flush:
  - In IDLE: suppresses accept.
  - In BUSY: sets discard. The transaction still runs to ack/timeout because the bus cannot be aborted, and stall_req stays high until it ends.
  - Discarded completions do not write load_data and skip DONE.
- Stores leave load_data unchanged.
- bus_ack outside BUSY is ignored.

Test Plan:
- LB with sign, addr 0x1003, rdata 0x80112233, ack on the first bus cycle -> bus_sel 1000, bus_addr 0x1000, stall_req high 2 cycles, load_data 0xFFFFFF80 in DONE.
- LHU addr 0x2002, rdata 0xBEEF1234, ack after 3 wait cycles -> bus_sel 1100, load_data 0x0000BEEF, stall_req high 5 cycles.
- SB data 0x000000A5, addr 0x0001 -> bus_we 1, bus_sel 0010, bus_wdata 0xA5A5A5A5; load_data unchanged.
- LW addr 0x0006 -> addr_err_load 1, bus_en never rises, stall_req 0.
- SH addr 0x0003 -> addr_err_store 1, no bus cycle.
- LW with no ack, TIMEOUT_CYCLES = 4 -> bus_en drops after 4 BUSY cycles, bus_err pulses 1 cycle in DONE, load_data 0.
- LW with flush asserted during BUSY, then ack with 0x12345678 -> load_data keeps its old value, DONE skipped, stall_req falls the cycle after ack.
- rst asserted in BUSY -> bus_en 0 and stall_req 0 on the next edge.
